// File: rtl/led_source_scheduler.sv
// rtl/led_source_scheduler.sv - round-robin burst scheduler for one shared LED pixel channel
// Optional watchdog release of stalled grants: define SCHED_TIMEOUT_EN.
module led_source_scheduler #(
  parameter int NUM_SOURCES    = 8,
  parameter int BURST_LEN      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_SOURCES-1:0]         req,
  input  logic                           beat,
  output logic [NUM_SOURCES-1:0]         select,
  output logic                           grant_valid,
  output logic [$clog2(NUM_SOURCES)-1:0] granted_index,
  output logic                           burst_done,
  output logic                           timeout
);

  localparam int IDX_W = $clog2(NUM_SOURCES);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HANDOFF
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SOURCES-1:0]   select_q, select_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic                     burst_done_q, burst_done_d;
  logic                     release_grant;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  // Search upward from ptr with wrap; descending scan keeps the nearest hit.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      if (req[ptr_q + IDX_W'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    burst_done_d  = 1'b0;
    release_grant = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HANDOFF: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
`ifdef SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // The beat is counted before a same-cycle request drop releases the grant.
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            burst_done_d  = 1'b1;
            release_grant = 1'b1;
          end
        end
        if (!req[owner_q]) begin
          release_grant = 1'b1;
        end
`ifdef SCHED_TIMEOUT_EN
        if (beat) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          release_grant = 1'b1;
          timeout_d     = req[owner_q];
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
        if (release_grant) begin
          state_d = ST_HANDOFF;
          ptr_d   = owner_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    grant_valid_d = (state_d == ST_GRANT);
    select_d      = grant_valid_d ? (NUM_SOURCES'(1) << owner_d) : '0;
    gidx_d        = grant_valid_d ? owner_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      select_q      <= '0;
      grant_valid_q <= 1'b0;
      gidx_q        <= '0;
      burst_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      select_q      <= select_d;
      grant_valid_q <= grant_valid_d;
      gidx_q        <= gidx_d;
      burst_done_q  <= burst_done_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign select        = select_q;
  assign grant_valid   = grant_valid_q;
  assign granted_index = gidx_q;
  assign burst_done    = burst_done_q;

endmodule

// File: tb/tb_led_source_scheduler.sv
// tb/tb_led_source_scheduler.sv - directed and random checks of led_source_scheduler against a reference model
// Two instances share stimulus: BURST_LEN=4 and BURST_LEN=1 (TIMEOUT_CYCLES=16, SCHED_TIMEOUT_EN optional).
module tb_led_source_scheduler;

`ifdef SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       beat;

  logic [7:0] sel4, sel1;
  logic       gv4, gv1, bd4, bd1, to4, to1;
  logic [2:0] gi4, gi1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_source_scheduler #(.NUM_SOURCES(8), .BURST_LEN(4), .TIMEOUT_CYCLES(TO_CYC)) dut4 (
    .clk(clk), .reset_n(reset_n), .req(req), .beat(beat),
    .select(sel4), .grant_valid(gv4), .granted_index(gi4),
    .burst_done(bd4), .timeout(to4)
  );

  led_source_scheduler #(.NUM_SOURCES(8), .BURST_LEN(1), .TIMEOUT_CYCLES(TO_CYC)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .beat(beat),
    .select(sel1), .grant_valid(gv1), .granted_index(gi1),
    .burst_done(bd1), .timeout(to1)
  );

  // phase: 0 idle, 1 owner holds the channel, 2 one-cycle gap
  typedef struct {
    int phase;
    int owner;
    int ptr;
    int cnt;
    int wd;
    bit bd;
    bit to;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mstep(mdl_t m, logic [7:0] r, logic b, int blen);
    mdl_t n = m;
    bit   rel = 1'b0;
    n.bd = 1'b0;
    n.to = 1'b0;
    if (m.phase == 1) begin
      if (b) begin
        n.cnt = m.cnt + 1;
        n.wd  = 0;
        if (n.cnt == blen) begin
          n.bd = 1'b1;
          rel  = 1'b1;
        end
      end else begin
        n.wd = m.wd + 1;
        if (TO_EN && r[m.owner] && n.wd == TO_CYC) begin
          n.to = 1'b1;
          rel  = 1'b1;
        end
      end
      if (!r[m.owner]) rel = 1'b1;
      if (rel) begin
        n.phase = 2;
        n.ptr   = (m.owner + 1) % 8;
      end
    end else begin
      int pick = -1;
      for (int k = 7; k >= 0; k--) begin
        if (r[(m.ptr + k) % 8]) pick = (m.ptr + k) % 8;
      end
      if (pick >= 0) begin
        n.phase = 1;
        n.owner = pick;
        n.cnt   = 0;
        n.wd    = 0;
      end else begin
        n.phase = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_sel(mdl_t m);
    return (m.phase == 1) ? 8'(1 << m.owner) : 8'h00;
  endfunction

  function automatic logic [7:0] exp_gi(mdl_t m);
    return (m.phase == 1) ? 8'(m.owner) : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("sel_b4", sel4, exp_sel(m4));
    chk("gv_b4", {7'd0, gv4}, {7'd0, m4.phase == 1});
    chk("gi_b4", {5'd0, gi4}, exp_gi(m4));
    chk("bd_b4", {7'd0, bd4}, {7'd0, m4.bd});
    chk("to_b4", {7'd0, to4}, {7'd0, m4.to});
    chk("sel_b1", sel1, exp_sel(m1));
    chk("gv_b1", {7'd0, gv1}, {7'd0, m1.phase == 1});
    chk("gi_b1", {5'd0, gi1}, exp_gi(m1));
    chk("bd_b1", {7'd0, bd1}, {7'd0, m1.bd});
    chk("to_b1", {7'd0, to1}, {7'd0, m1.to});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m4 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      m4 = mstep(m4, req, beat, 4);
      m1 = mstep(m1, req, beat, 1);
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    m4      = '{default: 0};
    m1      = '{default: 0};
    reset_n = 1'b0;
    req     = 8'hFF;
    beat    = 1'b0;

    // reset held with every source requesting
    tick();
    tick();
    chk("rst_sel", sel4, 8'h00);
    reset_n = 1'b1;
    tick();
    chk("first_sel", sel4, 8'h01);
    chk("first_gi", {5'd0, gi4}, 8'h00);
    chk("first_gv", {7'd0, gv4}, 8'h01);

    // full rotation with continuous beats, including 80 -> 00 -> 01 wrap
    beat = 1'b1;
    for (int i = 0; i < 45; i++) tick();

    // sparse requesters 4 and 7 from pointer 0
    do_reset();
    req = 8'h90;
    tick();
    chk("p90_first", sel4, 8'h10);
    for (int i = 0; i < 20; i++) tick();

    // grant source 2, drop its request after 3 beats
    do_reset();
    req  = 8'h2C;
    beat = 1'b0;
    tick();
    chk("src2_grant", sel4, 8'h04);
    beat = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    beat = 1'b0;
    req  = 8'h28;
    tick();
    chk("drop_gap", sel4, 8'h00);
    chk("drop_nobd", {7'd0, bd4}, 8'h00);
    tick();
    chk("drop_next", sel4, 8'h08);
    for (int i = 0; i < 4; i++) tick();

    // lone requester re-granted after single-cycle gaps
    req  = 8'h20;
    beat = 1'b1;
    for (int i = 0; i < 16; i++) tick();

    // asynchronous reset in the middle of a burst
    do_reset();
    req  = 8'hFF;
    beat = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_sel", sel4, 8'h00);
    chk("async_gv", {7'd0, gv4}, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk("restart_sel", sel4, 8'h01);

    // stalled grant with no beats
    do_reset();
    req  = 8'h03;
    beat = 1'b0;
    for (int i = 0; i < 24; i++) tick();

    // randomized traffic with occasional request changes
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom_range(0, 255));
      beat = ($urandom_range(0, 3) != 0);
      tick();
    end

    // BURST_LEN=1 gets burst_done after every accepted beat
    do_reset();
    req  = 8'h41;
    beat = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
